// File: rtl/cache_refill_ctrl_if.sv
// Memory-side bundle of the cache refill engine: the system bus beat handshake
// and the cache data memory port.
//   master : the refill engine (drives requests, cache writes)
//   slave  : bus / data memory side (drives ack, read data)
// Signals:
//   bus_req/bus_we/bus_addr/bus_wdata  request side of a single-word bus beat
//   bus_ack/bus_rdata                  completion of the beat, read data with ack
//   cmem_addr/cmem_we/cmem_wdata       cache data memory write/read address
//   cmem_rdata                         synchronous read data, one cycle after addr
interface cache_refill_ctrl_if #(
  parameter int unsigned CMEM_AW = 13
);
  logic               bus_req;
  logic               bus_we;
  logic [31:0]        bus_addr;
  logic [31:0]        bus_wdata;
  logic               bus_ack;
  logic [31:0]        bus_rdata;
  logic [CMEM_AW-1:0] cmem_addr;
  logic               cmem_we;
  logic [31:0]        cmem_wdata;
  logic [31:0]        cmem_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata, cmem_addr, cmem_we, cmem_wdata,
    input  bus_ack, bus_rdata, cmem_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata, cmem_addr, cmem_we, cmem_wdata,
    output bus_ack, bus_rdata, cmem_rdata
  );
endinterface

// File: rtl/cache_refill_ctrl.sv
// Line refill / writeback engine for the tag arbiter. Writes dirty victims back
// word by word, fetches missing lines into cache data memory and signals
// completion with one-cycle writeback_ok / line_refill pulses. Keeps a shadow
// copy of each entry's tag to form writeback addresses; services force_sync.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   line_miss          refill request from the arbiter
//   replace_dirty      selected victim (or flush candidate) is dirty
//   entry_replace_sel  victim / flush entry index, sampled in idle only
//   force_sync         flush all dirty lines
//   access_addr        core access address, tag used for refill
//   refill_pa          base address of the line being refilled
//   line_refill        pulse: refill of latched entry complete
//   writeback_ok       pulse: writeback of latched entry complete
//   busy               engine not idle
//   mem                bus + cache data memory bundle (master side)
module cache_refill_ctrl #(
  parameter int unsigned ENTRY_NUM    = 8,
  parameter int unsigned SEL_WIDTH    = (ENTRY_NUM > 1) ? $clog2(ENTRY_NUM) : 1,
  parameter int unsigned TAG_LSB      = 12,
  parameter int unsigned OFFSET_WIDTH = TAG_LSB - 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 line_miss,
  input  logic                 replace_dirty,
  input  logic [SEL_WIDTH-1:0] entry_replace_sel,
  input  logic                 force_sync,
  input  logic [31:0]          access_addr,
  output logic [31:0]          refill_pa,
  output logic                 line_refill,
  output logic                 writeback_ok,
  output logic                 busy,
  cache_refill_ctrl_if.master  mem
);
  localparam int unsigned TagWidth = 32 - TAG_LSB;

  typedef enum logic [2:0] {StIdle, StWbRd, StWbBus, StRfBus, StRfWr} state_e;

  state_e                  state_q, state_d;
  logic [SEL_WIDTH-1:0]    sel_q, sel_d;
  logic [OFFSET_WIDTH-1:0] offset_q, offset_d;
  logic [TagWidth-1:0]     rtag_q, rtag_d;
  logic [TagWidth-1:0]     shadow_q [ENTRY_NUM];
  logic                    wb_first_q;
  logic [31:0]             bus_wdata_q;
  logic [31:0]             cmem_wdata_q;
  logic                    line_refill_q, line_refill_d;
  logic                    writeback_ok_q, writeback_ok_d;
  logic                    shadow_we;
  logic                    last_word;
  logic                    dirty_eff, miss_eff;
  logic                    unused_addr_bits;

  assign unused_addr_bits = ^access_addr[TAG_LSB-1:0];
  assign last_word        = &offset_q;

  // During the idle cycle carrying a completion pulse the arbiter has not yet
  // cleared dirty state / installed the tag; ignore the stale request for it.
  assign dirty_eff = replace_dirty & ~writeback_ok_q;
  assign miss_eff  = line_miss & ~line_refill_q;

  always_comb begin
    state_d        = state_q;
    sel_d          = sel_q;
    offset_d       = offset_q;
    rtag_d         = rtag_q;
    line_refill_d  = 1'b0;
    writeback_ok_d = 1'b0;
    shadow_we      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if ((force_sync || miss_eff) && dirty_eff) begin
          sel_d    = entry_replace_sel;
          offset_d = '0;
          state_d  = StWbRd;
        end else if (miss_eff) begin
          sel_d    = entry_replace_sel;
          rtag_d   = access_addr[31:TAG_LSB];
          offset_d = '0;
          state_d  = StRfBus;
        end
      end
      StWbRd: state_d = StWbBus;
      StWbBus: begin
        if (mem.bus_ack) begin
          if (last_word) begin
            writeback_ok_d = 1'b1;
            offset_d       = '0;
            state_d        = StIdle;
          end else begin
            offset_d = offset_q + 1'b1;
            state_d  = StWbRd;
          end
        end
      end
      StRfBus: begin
        if (mem.bus_ack) state_d = StRfWr;
      end
      StRfWr: begin
        if (last_word) begin
          line_refill_d = 1'b1;
          shadow_we     = 1'b1;
          offset_d      = '0;
          state_d       = StIdle;
        end else begin
          offset_d = offset_q + 1'b1;
          state_d  = StRfBus;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    mem.bus_req   = 1'b0;
    mem.bus_we    = 1'b0;
    mem.bus_addr  = '0;
    mem.cmem_addr = '0;
    mem.cmem_we   = 1'b0;
    unique case (state_q)
      StWbRd: mem.cmem_addr = {sel_q, offset_q};
      StWbBus: begin
        mem.bus_req  = 1'b1;
        mem.bus_we   = 1'b1;
        mem.bus_addr = {shadow_q[sel_q], offset_q, 2'b00};
      end
      StRfBus: begin
        mem.bus_req  = 1'b1;
        mem.bus_addr = {rtag_q, offset_q, 2'b00};
      end
      StRfWr: begin
        mem.cmem_we   = 1'b1;
        mem.cmem_addr = {sel_q, offset_q};
      end
      default: ;
    endcase
  end

  // Read data arrives in the first WB_BUS cycle; pass it straight through so a
  // zero-wait ack writes the right word, and hold a copy for later wait cycles.
  assign mem.bus_wdata  = wb_first_q ? mem.cmem_rdata : bus_wdata_q;
  assign mem.cmem_wdata = cmem_wdata_q;
  assign refill_pa      = {rtag_q, {TAG_LSB{1'b0}}};
  assign busy           = (state_q != StIdle);
  assign line_refill    = line_refill_q;
  assign writeback_ok   = writeback_ok_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      sel_q          <= '0;
      offset_q       <= '0;
      rtag_q         <= '0;
      wb_first_q     <= 1'b0;
      bus_wdata_q    <= '0;
      cmem_wdata_q   <= '0;
      line_refill_q  <= 1'b0;
      writeback_ok_q <= 1'b0;
      for (int unsigned i = 0; i < ENTRY_NUM; i++) shadow_q[i] <= '0;
    end else begin
      state_q        <= state_d;
      sel_q          <= sel_d;
      offset_q       <= offset_d;
      rtag_q         <= rtag_d;
      line_refill_q  <= line_refill_d;
      writeback_ok_q <= writeback_ok_d;
      wb_first_q     <= (state_q == StWbRd);
      if (wb_first_q) bus_wdata_q <= mem.cmem_rdata;
      if (state_q == StRfBus && mem.bus_ack) cmem_wdata_q <= mem.bus_rdata;
      if (shadow_we) shadow_q[sel_q] <= rtag_q;
    end
  end
endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Bench for cache_refill_ctrl with a small line (TAG_LSB=4, 4 words per line).
// Expected bus beats and cache writes go into scoreboard queues when a
// transaction is launched and are popped by a negedge monitor.
module tb_cache_refill_ctrl;
  localparam int unsigned ENTRY_NUM = 8;
  localparam int unsigned SEL_W     = 3;
  localparam int unsigned TAG_LSB   = 4;
  localparam int unsigned OFF_W     = TAG_LSB - 2;
  localparam int unsigned TAG_W     = 32 - TAG_LSB;
  localparam int unsigned WORDS     = 1 << OFF_W;
  localparam int unsigned CAW       = SEL_W + OFF_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst, line_miss, force_sync, load_dirty;
  logic [SEL_W-1:0]     miss_sel, entry_replace_sel;
  logic [ENTRY_NUM-1:0] dirty, dirty_init;
  logic                 replace_dirty;
  logic [31:0]          access_addr, refill_pa;
  logic                 line_refill, writeback_ok, busy;
  int                   wait_n = 0;
  int                   wcnt = 0;

  cache_refill_ctrl_if #(.CMEM_AW(CAW)) mem_if ();

  cache_refill_ctrl #(
    .ENTRY_NUM(ENTRY_NUM),
    .TAG_LSB  (TAG_LSB)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .line_miss        (line_miss),
    .replace_dirty    (replace_dirty),
    .entry_replace_sel(entry_replace_sel),
    .force_sync       (force_sync),
    .access_addr      (access_addr),
    .refill_pa        (refill_pa),
    .line_refill      (line_refill),
    .writeback_ok     (writeback_ok),
    .busy             (busy),
    .mem              (mem_if.master)
  );

  function automatic logic [31:0] bus_data(input logic [31:0] a);
    return a ^ 32'hC3A5_0F0F;
  endfunction

  // Arbiter model: flush picks the highest dirty entry; dirty clears on writeback_ok.
  function automatic logic [SEL_W-1:0] flush_pick(input logic [ENTRY_NUM-1:0] d);
    logic [SEL_W-1:0] p = '0;
    for (int i = 0; i < ENTRY_NUM; i++) if (d[i]) p = SEL_W'(i);
    return p;
  endfunction

  always_comb begin
    entry_replace_sel = miss_sel;
    if (force_sync) entry_replace_sel = flush_pick(dirty);
  end
  assign replace_dirty = dirty[entry_replace_sel];

  always @(posedge clk) begin
    if (rst) dirty <= '0;
    else if (load_dirty) dirty <= dirty_init;
    else if (writeback_ok) dirty[entry_replace_sel] <= 1'b0;
  end

  // Bus responder: ack after wait_n wait cycles, read data derived from address.
  always @(posedge clk) begin
    if (!mem_if.bus_req || mem_if.bus_ack) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end
  assign mem_if.bus_ack   = mem_if.bus_req && (wcnt == wait_n);
  assign mem_if.bus_rdata = bus_data(mem_if.bus_addr);

  // Cache data memory with synchronous read.
  logic [31:0] cmem_mem [1 << CAW];
  logic [31:0] cmem_rd_q;
  always @(posedge clk) begin
    if (mem_if.cmem_we) cmem_mem[mem_if.cmem_addr] <= mem_if.cmem_wdata;
    cmem_rd_q <= cmem_mem[mem_if.cmem_addr];
  end
  assign mem_if.cmem_rdata = cmem_rd_q;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } beat_t;
  typedef struct packed {
    logic [CAW-1:0] addr;
    logic [31:0]    data;
  } cw_t;

  beat_t       bus_q[$];
  cw_t         cmem_q[$];
  logic [31:0] exp_line [ENTRY_NUM][WORDS];
  logic [TAG_W-1:0] exp_shadow [ENTRY_NUM];

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: bus beats, cache writes, request stability, pulse exclusivity.
  initial begin
    logic        prev_wait = 1'b0;
    logic        prev_we = 1'b0;
    logic [31:0] prev_addr = '0, prev_wdata = '0;
    beat_t       b;
    cw_t         c;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_wait = 1'b0;
      end else begin
        if (mem_if.bus_req && prev_wait) begin
          check("bus_addr_hold", mem_if.bus_addr, prev_addr);
          check("bus_we_hold", mem_if.bus_we, prev_we);
          if (prev_we) check("bus_wdata_hold", mem_if.bus_wdata, prev_wdata);
        end
        if (mem_if.bus_req && mem_if.bus_ack) begin
          checks++;
          if (bus_q.size() == 0) begin
            failures++;
            $display("FAIL bus_beat: unexpected beat addr %0h", mem_if.bus_addr);
          end else begin
            checks--;
            b = bus_q.pop_front();
            check("bus_we", mem_if.bus_we, b.we);
            check("bus_addr", mem_if.bus_addr, b.addr);
            if (b.we) check("bus_wdata", mem_if.bus_wdata, b.data);
          end
        end
        if (mem_if.cmem_we) begin
          checks++;
          if (cmem_q.size() == 0) begin
            failures++;
            $display("FAIL cmem_write: unexpected write addr %0h", mem_if.cmem_addr);
          end else begin
            checks--;
            c = cmem_q.pop_front();
            check("cmem_addr", mem_if.cmem_addr, c.addr);
            check("cmem_wdata", mem_if.cmem_wdata, c.data);
          end
        end
        if (line_refill || writeback_ok)
          check("pulse_exclusive", line_refill & writeback_ok, 1'b0);
        prev_wait  = mem_if.bus_req && !mem_if.bus_ack;
        prev_we    = mem_if.bus_we;
        prev_addr  = mem_if.bus_addr;
        prev_wdata = mem_if.bus_wdata;
      end
    end
  end

  typedef struct {
    logic [SEL_W-1:0] sel;
    logic [31:0]      addr;
    bit               dirty;
    int               wait_n;
    int               exp_busy;
    logic [31:0]      exp_pa;
  } vec_t;

  task automatic push_wb(input logic [SEL_W-1:0] sel, input int beats);
    beat_t b;
    for (int off = 0; off < beats; off++) begin
      b.we   = 1'b1;
      b.addr = {exp_shadow[sel], OFF_W'(off), 2'b00};
      b.data = exp_line[sel][off];
      bus_q.push_back(b);
    end
  endtask

  task automatic load_dirty_bits(input logic [ENTRY_NUM-1:0] bits);
    dirty_init = bits;
    load_dirty = 1'b1;
    @(negedge clk);
    load_dirty = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int               busy_n = 0, wbp = 0, rfp = 0, cyc = 0;
    bit               done = 1'b0;
    logic [TAG_W-1:0] tag;
    logic [ENTRY_NUM-1:0] bits = '0;
    beat_t            b;
    cw_t              c;
    @(negedge clk);
    wait_n   = v.wait_n;
    miss_sel = v.sel;
    bits[v.sel] = v.dirty;
    load_dirty_bits(bits);
    if (v.dirty) push_wb(v.sel, WORDS);
    tag = v.addr[31:TAG_LSB];
    for (int off = 0; off < WORDS; off++) begin
      b.we   = 1'b0;
      b.addr = {tag, OFF_W'(off), 2'b00};
      b.data = '0;
      bus_q.push_back(b);
      c.addr = {v.sel, OFF_W'(off)};
      c.data = bus_data(b.addr);
      cmem_q.push_back(c);
      exp_line[v.sel][off] = c.data;
    end
    access_addr = v.addr;
    line_miss   = 1'b1;
    while (!done && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (busy) busy_n++;
      if (writeback_ok) wbp++;
      if (line_refill) begin
        rfp++;
        done = 1'b1;
      end
    end
    line_miss = 1'b0;
    exp_shadow[v.sel] = tag;
    check($sformatf("v%0d_done", idx), done, 1'b1);
    check($sformatf("v%0d_busy_cycles", idx), busy_n, v.exp_busy);
    check($sformatf("v%0d_latency", idx), cyc, v.exp_busy + 1 + int'(v.dirty));
    check($sformatf("v%0d_wb_pulses", idx), wbp, int'(v.dirty));
    check($sformatf("v%0d_rf_pulses", idx), rfp, 1);
    check($sformatf("v%0d_refill_pa", idx), refill_pa, v.exp_pa);
    @(negedge clk);
    check($sformatf("v%0d_idle_busy", idx), busy, 1'b0);
    check($sformatf("v%0d_pulse_width", idx), line_refill, 1'b0);
  endtask

  vec_t vecs[7];

  initial begin
    int   wbp, rfp, cyc;
    bit   seen;
    vec_t rv;
    // sel, access_addr, dirty, wait, busy cycles, refill_pa
    vecs[0] = '{3'd3, 32'h0003_5004, 1'b0, 0, 8,  32'h0003_5000};
    vecs[1] = '{3'd2, 32'h0000_0124, 1'b0, 0, 8,  32'h0000_0120};
    vecs[2] = '{3'd2, 32'h0ABC_DEF8, 1'b1, 0, 16, 32'h0ABC_DEF0};
    vecs[3] = '{3'd5, 32'h7777_0000, 1'b0, 1, 12, 32'h7777_0000};
    vecs[4] = '{3'd1, 32'hFFFF_FFF0, 1'b0, 0, 8,  32'hFFFF_FFF0};
    vecs[5] = '{3'd5, 32'h0000_1230, 1'b1, 2, 32, 32'h0000_1230};
    vecs[6] = '{3'd0, 32'h0000_4568, 1'b0, 3, 20, 32'h0000_4560};
    for (int e = 0; e < ENTRY_NUM; e++) exp_shadow[e] = '0;

    rst = 1'b1; line_miss = 1'b0; force_sync = 1'b0; load_dirty = 1'b0;
    miss_sel = '0; dirty_init = '0; access_addr = '0;
    repeat (3) @(negedge clk);
    check("rst_bus_req", mem_if.bus_req, 1'b0);
    check("rst_bus_we", mem_if.bus_we, 1'b0);
    check("rst_cmem_we", mem_if.cmem_we, 1'b0);
    check("rst_line_refill", line_refill, 1'b0);
    check("rst_writeback_ok", writeback_ok, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_refill_pa", refill_pa, 32'h0);
    check("rst_bus_addr", mem_if.bus_addr, 32'h0);
    check("rst_bus_wdata", mem_if.bus_wdata, 32'h0);
    check("rst_cmem_wdata", mem_if.cmem_wdata, 32'h0);
    check("rst_cmem_addr", mem_if.cmem_addr, '0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Flush: entries 1 and 5 dirty, arbiter selects 5 first.
    @(negedge clk);
    wait_n = 0;
    push_wb(3'd5, WORDS);
    push_wb(3'd1, WORDS);
    load_dirty_bits(8'b0010_0010);
    force_sync = 1'b1;
    wbp = 0; rfp = 0; cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (writeback_ok) wbp++;
      if (line_refill) rfp++;
    end while ((dirty != '0 || busy) && cyc < 400);
    check("flush_done", cyc < 400, 1'b1);
    check("flush_wb_pulses", wbp, 2);
    check("flush_rf_pulses", rfp, 0);
    repeat (3) begin
      @(negedge clk);
      check("flush_idle", busy, 1'b0);
    end
    force_sync = 1'b0;
    check("flush_queue_empty", bus_q.size(), 0);

    // Reset in the middle of a writeback, second beat pending.
    wait_n   = 3;
    miss_sel = 3'd3;
    load_dirty_bits(8'b0000_1000);
    push_wb(3'd3, 1);
    line_miss = 1'b1;
    seen = 1'b0; cyc = 0;
    while (!seen && cyc < 100) begin
      @(negedge clk);
      cyc++;
      seen = mem_if.bus_req && mem_if.bus_ack;
    end
    check("rstwb_first_beat", seen, 1'b1);
    repeat (2) @(negedge clk);
    check("rstwb_req_pending", mem_if.bus_req, 1'b1);
    rst = 1'b1;
    line_miss = 1'b0;
    @(negedge clk);
    check("rstwb_bus_req", mem_if.bus_req, 1'b0);
    check("rstwb_busy", busy, 1'b0);
    check("rstwb_line_refill", line_refill, 1'b0);
    check("rstwb_writeback_ok", writeback_ok, 1'b0);
    rst = 1'b0;
    for (int e = 0; e < ENTRY_NUM; e++) exp_shadow[e] = '0;

    // Restart from offset 0; then a dirty miss writes back to the cleared shadow tag.
    rv = '{3'd3, 32'h0000_9994, 1'b0, 0, 8, 32'h0000_9990};
    run_vec(rv, 7);
    rv = '{3'd0, 32'h0000_2220, 1'b1, 0, 16, 32'h0000_2220};
    run_vec(rv, 8);

    check("bus_queue_empty", bus_q.size(), 0);
    check("cmem_queue_empty", cmem_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end
endmodule
